fust_g_sched: RTL

- Issue scheduler for the G (GEMM) functional unit.
- Holds up to DEPTH decoded G ops, each waiting on up to three producer tags (t1..t3). Clears tags from the writeback broadcast.
- Dispatches the oldest fully-ready op to the G unit over a valid/ready handshake.
- Kills speculative ops on flush and clears speculation on resolve. Sits between decode/scoreboard and the G-unit status entry.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/fust_g_sched_wakeup.sv | 25 ++
 rtl/fust_g_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the G-unit issue scheduler: queue entry layout and tag constants.
package datapath_pkg;

  localparam int G_DEPTH = 4;
  localparam int G_TAG_W = 5;
  localparam int G_OP_W  = 32;

  localparam logic [G_TAG_W-1:0] TAG_READY = '0;

  // Field widths are fixed here, so the scheduler's TAG_W/OP_W must match G_TAG_W/G_OP_W.
  typedef struct packed {
    logic              valid;
    logic              spec;
    logic [G_OP_W-1:0] op;
    logic [G_TAG_W-1:0] t1;
    logic [G_TAG_W-1:0] t2;
    logic [G_TAG_W-1:0] t3;
  } fust_g_sched_entry_t;

endpackage

// File: rtl/fust_g_sched_wakeup.sv
// Clears any of one op's three producer tags that match the current writeback broadcast.
module fust_g_sched_wakeup
  import datapath_pkg::*;
#(
  parameter int TAG_W = G_TAG_W
) (
  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic [TAG_W-1:0] t1_i,
  input  logic [TAG_W-1:0] t2_i,
  input  logic [TAG_W-1:0] t3_i,
  output logic [TAG_W-1:0] t1_o,
  output logic [TAG_W-1:0] t2_o,
  output logic [TAG_W-1:0] t3_o
);

  // Tag 0 already means "ready", so a zero broadcast must never match anything.
  logic hitEn;
  assign hitEn = wb_valid_i && (wb_tag_i != '0);

  assign t1_o = (hitEn && (t1_i == wb_tag_i)) ? '0 : t1_i;
  assign t2_o = (hitEn && (t2_i == wb_tag_i)) ? '0 : t2_i;
  assign t3_o = (hitEn && (t3_i == wb_tag_i)) ? '0 : t3_i;

endmodule

// File: rtl/fust_g_sched.sv
// Issue scheduler for the G unit: collapsing age-ordered queue, tag wakeup,
// oldest-ready select with a sticky offer lock, and speculative flush/resolve.
module fust_g_sched
  import datapath_pkg::*;
#(
  parameter int DEPTH = G_DEPTH,
  parameter int TAG_W = G_TAG_W,
  parameter int OP_W  = G_OP_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic [OP_W-1:0]  op_in,
  input  logic             spec_in,
  input  logic [TAG_W-1:0] t1_in,
  input  logic [TAG_W-1:0] t2_in,
  input  logic [TAG_W-1:0] t3_in,
  output logic             full,
  output logic [CNT_W-1:0] count,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             flush,
  input  logic             resolve,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [OP_W-1:0]  disp_op,
  output logic             disp_spec
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fust_g_sched_entry_t entries_q [DEPTH];
  fust_g_sched_entry_t entries_d [DEPTH];
  fust_g_sched_entry_t incoming;

  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [TAG_W-1:0] wkT1 [DEPTH+1];
  logic [TAG_W-1:0] wkT2 [DEPTH+1];
  logic [TAG_W-1:0] wkT3 [DEPTH+1];

  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] sel;
  logic             offer;
  logic             deq;
  logic             accept;
  logic [CNT_W-1:0] wr;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    fust_g_sched_wakeup #(.TAG_W(TAG_W)) u_wake (
      .wb_valid_i (wb_valid),
      .wb_tag_i   (wb_tag),
      .t1_i       (entries_q[i].t1),
      .t2_i       (entries_q[i].t2),
      .t3_i       (entries_q[i].t3),
      .t1_o       (wkT1[i]),
      .t2_o       (wkT2[i]),
      .t3_o       (wkT3[i])
    );

    assign ready[i] = entries_q[i].valid && (entries_q[i].t1 == TAG_READY) &&
                      (entries_q[i].t2 == TAG_READY) && (entries_q[i].t3 == TAG_READY);
  end

  // Bypass path so an op enqueued during its producer's writeback still wakes up.
  fust_g_sched_wakeup #(.TAG_W(TAG_W)) u_wake_in (
    .wb_valid_i (wb_valid),
    .wb_tag_i   (wb_tag),
    .t1_i       (t1_in),
    .t2_i       (t2_in),
    .t3_i       (t3_in),
    .t1_o       (wkT1[DEPTH]),
    .t2_o       (wkT2[DEPTH]),
    .t3_o       (wkT3[DEPTH])
  );

  always_comb begin
    sel   = '0;
    offer = 1'b0;
    if (lock_valid_q) begin
      sel   = lock_idx_q;
      offer = 1'b1;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ready[i]) begin
          sel   = IDX_W'(i);
          offer = 1'b1;
        end
      end
    end
  end

  assign disp_valid = offer && !(flush && entries_q[sel].spec);
  assign disp_op    = offer ? entries_q[sel].op : '0;
  assign disp_spec  = offer ? entries_q[sel].spec : 1'b0;
  assign deq        = disp_valid && disp_ready;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign accept     = en && !full && !(flush && spec_in);

  always_comb begin
    incoming       = '0;
    incoming.valid = 1'b1;
    incoming.spec  = spec_in && !resolve;
    incoming.op    = op_in;
    incoming.t1    = wkT1[DEPTH];
    incoming.t2    = wkT2[DEPTH];
    incoming.t3    = wkT3[DEPTH];
  end

  // Survivors are packed down in age order; the offered entry's new slot is
  // recorded so a held offer follows it through the collapse.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = '0;
    end
    wr           = '0;
    lock_valid_d = disp_valid && !disp_ready;
    lock_idx_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && !(flush && entries_q[i].spec) &&
          !(deq && (IDX_W'(i) == sel))) begin
        entries_d[wr[IDX_W-1:0]].valid = 1'b1;
        entries_d[wr[IDX_W-1:0]].spec  = entries_q[i].spec && !resolve;
        entries_d[wr[IDX_W-1:0]].op    = entries_q[i].op;
        entries_d[wr[IDX_W-1:0]].t1    = wkT1[i];
        entries_d[wr[IDX_W-1:0]].t2    = wkT2[i];
        entries_d[wr[IDX_W-1:0]].t3    = wkT3[i];
        if (IDX_W'(i) == sel) begin
          lock_idx_d = wr[IDX_W-1:0];
        end
        wr = wr + CNT_W'(1);
      end
    end
    if (accept) begin
      entries_d[wr[IDX_W-1:0]] = incoming;
      wr = wr + CNT_W'(1);
    end
    count_d = wr;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q      <= count_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

endmodule
